// File: rtl/hm62256_seq_if.sv
// Command channel between the register file and the HM62256 access sequencer.
// Handshake: a command transfers on the rising clk edge where cmd_valid && cmd_ready.
// The requester holds cmd_valid and the payload stable until that edge.
// abort is a level request that the sequencer samples only while it is busy.
interface hm62256_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [14:0] cmd_addr;
  logic [14:0] cmd_len;
  logic [7:0]  cmd_wdata;
  logic        abort;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_wdata, abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_wdata, abort,
    output cmd_ready
  );
endinterface

// File: rtl/hm62256_seq.sv
// hm62256_seq: clocked /CE, /OE, /WE sequencer for the HM62256 32Kx8 SRAM.
// It runs single and burst reads/writes with programmable setup, pulse and hold lengths.
// Optional feature: define HM62256_SEQ_VERIFY_EN to compare burst-read bytes against
// cmd_wdata and report the first mismatch on err/err_addr.
// The strobes decode directly from the state register. Reset forces IDLE
// asynchronously, so it releases every strobe immediately.
module hm62256_seq #(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 4,
  parameter int HOLD_CYC  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  hm62256_seq_if.slave bus,
  output logic        busy,
  output logic        done,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic [14:0] dut_addr,
  output logic [7:0]  dut_dout,
  output logic        dut_doe,
  input  logic [7:0]  dut_din,
  output logic        dut_ce_n,
  output logic        dut_oe_n,
  output logic        dut_we_n,
`ifdef HM62256_SEQ_VERIFY_EN
  output logic        err,
  output logic [14:0] err_addr,
`endif
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_PULSE = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic [15:0] SETUP_LD = 16'(SETUP_CYC - 1);
  localparam logic [15:0] PULSE_LD = 16'(PULSE_CYC - 1);
  localparam logic [15:0] HOLD_LD  = 16'(HOLD_CYC - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  op_q;
  logic [14:0] addr_q;
  logic [14:0] remain_q;
  logic [7:0]  wdata_q;
  logic        abort_q;
  logic        done_q;
  logic        rd_valid_q;
  logic [7:0]  rd_data_q;

  logic accept;
  logic last;
  logic is_write;
  logic more;
  logic sample;

  // Op 01 and 10 drive the bus; 00 and 11 read it.
  assign is_write = op_q[0] ^ op_q[1];
  assign accept   = bus.cmd_valid && (state_q == S_IDLE);
  assign last     = (cnt_q == 16'd0);
  // Another beat follows only if accesses remain and no abort has been seen.
  assign more     = (remain_q != 15'd0) && !abort_q && !bus.abort;
  assign sample   = (state_q == S_PULSE) && last && !is_write;

  // State register and phase down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state. The counter is reloaded with the phase length minus 1 on every phase entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      S_SETUP: begin
        if (last) begin
          state_d = S_PULSE;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_PULSE: begin
        if (last) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        if (last) begin
          if (more) begin
            state_d = S_SETUP;
            cnt_d   = SETUP_LD;
          end else begin
            state_d = S_IDLE;
            cnt_d   = 16'd0;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
    endcase
  end

  // Strobe and status decode.
  // HOLD keeps doe high for writes, so oe_n low and doe high never overlap.
  always_comb begin
    busy          = (state_q != S_IDLE);
    bus.cmd_ready = (state_q == S_IDLE);
    dut_ce_n      = !((state_q == S_SETUP) || (state_q == S_PULSE));
    dut_we_n      = !((state_q == S_PULSE) && is_write);
    dut_oe_n      = !((state_q == S_PULSE) && !is_write);
    dut_doe       = (state_q != S_IDLE) && is_write;
    dut_addr      = addr_q;
    dut_dout      = wdata_q;
    done          = done_q;
    rd_valid      = rd_valid_q;
    rd_data       = rd_data_q;
    dbg_state     = state_q;
  end

  // Command latch, burst address/count stepping, abort flag, done and read capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= 2'b00;
      addr_q     <= 15'd0;
      remain_q   <= 15'd0;
      wdata_q    <= 8'h00;
      abort_q    <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      done_q     <= (state_q == S_HOLD) && last && !more;
      rd_valid_q <= sample;
      if (sample) begin
        rd_data_q <= dut_din;
      end
      if (accept) begin
        op_q     <= bus.cmd_op;
        addr_q   <= bus.cmd_addr;
        remain_q <= bus.cmd_op[1] ? bus.cmd_len : 15'd0;
        wdata_q  <= bus.cmd_wdata;
        abort_q  <= 1'b0;
      end else if (state_q != S_IDLE) begin
        if (bus.abort) begin
          abort_q <= 1'b1;
        end
        if ((state_q == S_HOLD) && last && more) begin
          addr_q   <= addr_q + 15'd1;
          remain_q <= remain_q - 15'd1;
        end
      end
    end
  end

`ifdef HM62256_SEQ_VERIFY_EN
  logic        err_q;
  logic [14:0] err_addr_q;

  // Sticky first-mismatch capture for burst reads; cleared when the next burst read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      err_addr_q <= 15'd0;
    end else if (accept && (bus.cmd_op == 2'b11)) begin
      err_q      <= 1'b0;
      err_addr_q <= 15'd0;
    end else if (sample && (op_q == 2'b11) && (dut_din != wdata_q) && !err_q) begin
      err_q      <= 1'b1;
      err_addr_q <= addr_q;
    end
  end

  assign err      = err_q;
  assign err_addr = err_addr_q;
`endif

endmodule

// File: tb/tb_hm62256_seq.sv
// Bench for hm62256_seq: behavioural SRAM on the pins and an access-level reference model.
// The model computes the expected access list, the expected read bytes, cycle counts and
// done timing for each command.
module tb_hm62256_seq;

  localparam int SETUP = 1;
  localparam int PULSE = 4;
  localparam int HOLD  = 1;
  localparam int T     = SETUP + PULSE + HOLD;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  hm62256_seq_if cif ();

  logic        busy, done, rd_valid;
  logic [7:0]  rd_data;
  logic [14:0] dut_addr;
  logic [7:0]  dut_dout;
  logic        dut_doe;
  logic [7:0]  din;
  logic        dut_ce_n, dut_oe_n, dut_we_n;
  logic [1:0]  dbg_state;
`ifdef HM62256_SEQ_VERIFY_EN
  logic        err;
  logic [14:0] err_addr;
`endif

  hm62256_seq #(.SETUP_CYC(SETUP), .PULSE_CYC(PULSE), .HOLD_CYC(HOLD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (cif),
    .busy     (busy),
    .done     (done),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .dut_addr (dut_addr),
    .dut_dout (dut_dout),
    .dut_doe  (dut_doe),
    .dut_din  (din),
    .dut_ce_n (dut_ce_n),
    .dut_oe_n (dut_oe_n),
    .dut_we_n (dut_we_n),
`ifdef HM62256_SEQ_VERIFY_EN
    .err      (err),
    .err_addr (err_addr),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Access descriptor: {is_write, addr[14:0], data[7:0], start_cycle[15:0]}
  logic [39:0] exp_q[$];

  function automatic logic [7:0] init_val(input logic [14:0] a);
    return a[7:0] ^ {1'b0, a[14:8]};
  endfunction

  // ---------------- SRAM pin model ----------------
  logic [7:0]  mem    [32768];
  bit          wr_seen[32768];
  bit          corrupt_en = 1'b0;
  logic [14:0] corrupt_a  = 15'd0;
  logic [7:0]  corrupt_x  = 8'h00;

  always @(posedge clk) begin
    if (!dut_we_n && !dut_ce_n) begin
      mem[dut_addr]     <= dut_dout;
      wr_seen[dut_addr] <= 1'b1;
    end
  end

  always_comb begin
    din = 8'h00;
    if (!dut_oe_n && !dut_ce_n) begin
      din = wr_seen[dut_addr] ? mem[dut_addr] : init_val(dut_addr);
      if (corrupt_en && (dut_addr == corrupt_a)) din = din ^ corrupt_x;
    end
  end

  // ---------------- reference memory ----------------
  logic [7:0] ref_mem [32768];
  bit         ref_seen[32768];
`ifdef HM62256_SEQ_VERIFY_EN
  bit          exp_err      = 1'b0;
  logic [14:0] exp_err_addr = 15'd0;
`endif

  // ---------------- pulse monitor ----------------
  int          acc_cyc  = 0;
  bit          mon_on   = 1'b1;
  int          overlap  = 0;
  int          we_len   = 0;
  int          oe_len   = 0;
  int          we_start = 0;
  int          oe_start = 0;
  logic [14:0] we_addr, oe_addr;
  logic [7:0]  we_data;

  task automatic pulse_end(input bit is_w, input int start, input int len,
                           input logic [14:0] a, input logic [7:0] d);
    logic [39:0] e;
    if (exp_q.size() == 0) begin
      check("acc_unexpected", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("acc_kind",  32'(is_w), 32'(e[39]));
      check("acc_addr",  32'(a), 32'(e[38:24]));
      check("acc_data",  32'(d), 32'(e[23:16]));
      check("acc_start", 32'(start), 32'(e[15:0]));
      check("acc_len",   32'(len), 32'(PULSE));
    end
  endtask

  // Reconstruct strobe pulses at each falling edge and compare them with the expected access list.
  always @(negedge clk) begin
    if (!dut_oe_n && dut_doe) overlap++;
    if (!mon_on) begin
      we_len = 0;
      oe_len = 0;
    end else begin
      if (!dut_we_n) begin
        if (we_len == 0) we_start = cyc - acc_cyc;
        we_len++;
        we_addr = dut_addr;
        we_data = dut_dout;
      end else if (we_len != 0) begin
        pulse_end(1'b1, we_start, we_len, we_addr, we_data);
        we_len = 0;
      end
      if (!dut_oe_n) begin
        if (oe_len == 0) oe_start = cyc - acc_cyc;
        oe_len++;
        oe_addr = dut_addr;
      end else if (oe_len != 0) begin
        // First HOLD cycle: the registered read byte is presented now.
        check("rd_valid_at_hold", 32'(rd_valid), 1);
        pulse_end(1'b0, oe_start, oe_len, oe_addr, rd_data);
        oe_len = 0;
      end
    end
  end

  // ---------------- driver ----------------
  // abort_k > 0 raises abort for the single cycle k after accept (cycle 1 = first SETUP).
  task automatic run_cmd(input logic [1:0] op, input logic [14:0] a, input logic [14:0] len,
                         input logic [7:0] wd, input int abort_k);
    int          n, k, w, doe_c, we_c, oe_c, rv_c;
    bit          is_w, got_done;
    logic [14:0] aa;
    logic [7:0]  rv;
    is_w = (op == 2'b01) || (op == 2'b10);
    n = op[1] ? (int'(len) + 1) : 1;
    if (abort_k > 0 && ((abort_k - 1) / T + 1) < n) n = (abort_k - 1) / T + 1;
`ifdef HM62256_SEQ_VERIFY_EN
    if (op == 2'b11) begin
      exp_err      = 1'b0;
      exp_err_addr = 15'd0;
    end
`endif
    for (int i = 0; i < n; i++) begin
      aa = a + 15'(i);
      if (is_w) begin
        ref_mem[aa]  = wd;
        ref_seen[aa] = 1'b1;
        exp_q.push_back({1'b1, aa, wd, 16'(1 + i * T + SETUP)});
      end else begin
        rv = ref_seen[aa] ? ref_mem[aa] : init_val(aa);
        if (corrupt_en && aa == corrupt_a) rv = rv ^ corrupt_x;
        exp_q.push_back({1'b0, aa, rv, 16'(1 + i * T + SETUP)});
`ifdef HM62256_SEQ_VERIFY_EN
        if (op == 2'b11 && rv != wd && !exp_err) begin
          exp_err      = 1'b1;
          exp_err_addr = aa;
        end
`endif
      end
    end

    w = 0;
    @(negedge clk);
    while (!cif.cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("cmd_ready_wait", 32'(cif.cmd_ready), 1);
    acc_cyc       = cyc;
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_addr  = a;
    cif.cmd_len   = len;
    cif.cmd_wdata = wd;
    @(posedge clk);
    #1;
    cif.cmd_valid = 1'b0;
    cif.cmd_addr  = 15'($urandom);
    cif.cmd_wdata = 8'($urandom);

    k = 1; got_done = 1'b0; doe_c = 0; we_c = 0; oe_c = 0; rv_c = 0;
    while (k <= n * T + 20) begin
      @(negedge clk);
      cif.abort = (k == abort_k);
      if (dut_doe)   doe_c++;
      if (!dut_we_n) we_c++;
      if (!dut_oe_n) oe_c++;
      if (rd_valid)  rv_c++;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      @(posedge clk);
      k++;
    end
    cif.abort = 1'b0;
    check("done_seen",   32'(got_done), 1);
    check("done_cycle",  32'(k), 32'(1 + n * T));
    check("doe_cycles",  32'(doe_c), is_w ? 32'(n * T) : 32'd0);
    check("we_cycles",   32'(we_c),  is_w ? 32'(n * PULSE) : 32'd0);
    check("oe_cycles",   32'(oe_c),  is_w ? 32'd0 : 32'(n * PULSE));
    check("rd_valid_cnt", 32'(rv_c), is_w ? 32'd0 : 32'(n));
    check("acc_left",    32'(exp_q.size()), 0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
    check("busy_after",     32'(busy), 0);
`ifdef HM62256_SEQ_VERIFY_EN
    check("err",      32'(err), 32'(exp_err));
    check("err_addr", 32'(err_addr), 32'(exp_err_addr));
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int       kk;
    logic [1:0]  op;
    logic [14:0] len;
    int          ab;
    rst_n         = 1'b0;
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 2'b00;
    cif.cmd_addr  = 15'd0;
    cif.cmd_len   = 15'd0;
    cif.cmd_wdata = 8'h00;
    cif.abort     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ce_n", 32'(dut_ce_n), 1);
    check("rst_oe_n", 32'(dut_oe_n), 1);
    check("rst_we_n", 32'(dut_we_n), 1);
    check("rst_doe",  32'(dut_doe), 0);
    check("rst_addr", 32'(dut_addr), 0);
    check("rst_dout", 32'(dut_dout), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data",  32'(rd_data), 0);
    check("rst_ready",    32'(cif.cmd_ready), 1);
`ifdef HM62256_SEQ_VERIFY_EN
    check("rst_err",      32'(err), 0);
    check("rst_err_addr", 32'(err_addr), 0);
`endif
    rst_n = 1'b1;

    // Single write, single read of a known byte
    run_cmd(2'b01, 15'h1234, 15'd0, 8'hA5, 0);
    run_cmd(2'b01, 15'h0042, 15'd0, 8'h5A, 0);
    run_cmd(2'b00, 15'h0042, 15'($urandom), 8'h00, 0);
    // Burst write across the address wrap, then read it back
    run_cmd(2'b10, 15'h7FFE, 15'd3, 8'h3C, 0);
    run_cmd(2'b11, 15'h7FFE, 15'd3, 8'h3C, 0);
    // Burst write of 10 aborted mid-PULSE of beat 2
    run_cmd(2'b10, 15'h0100, 15'd9, 8'h77, T + SETUP + 2);
    run_cmd(2'b11, 15'h0100, 15'd3, 8'h77, 0);
    // Burst read of 8 with one corrupted byte at 0x0005
    run_cmd(2'b10, 15'h0000, 15'd7, 8'hFF, 0);
    corrupt_en = 1'b1;
    corrupt_a  = 15'h0005;
    corrupt_x  = 8'h01;
    run_cmd(2'b11, 15'h0000, 15'd7, 8'hFF, 0);
    corrupt_en = 1'b0;
    // Abort raised in IDLE only: ignored
    cif.abort = 1'b1;
    repeat (2) @(negedge clk);
    cif.abort = 1'b0;
    run_cmd(2'b10, 15'h0200, 15'd1, 8'h11, 0);

    // Randomized commands; aborts land in SETUP or PULSE of a random beat
    for (int r = 0; r < 14; r++) begin
      op  = 2'($urandom_range(0, 3));
      len = 15'($urandom_range(0, 4));
      ab  = 0;
      if ($urandom_range(0, 2) == 0)
        ab = ($urandom_range(0, int'(len))) * T + 1 + $urandom_range(0, T - 2);
      if ($urandom_range(0, 1) == 0)
        run_cmd(op, 15'($urandom_range(0, 15)) + 15'h7FF8, len, 8'($urandom), ab);
      else
        run_cmd(op, 15'($urandom), len, 8'($urandom), ab);
    end

    // Reset asserted in the middle of a write pulse
    mon_on = 1'b0;
    @(negedge clk);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = 2'b01;
    cif.cmd_addr  = 15'h3000;
    cif.cmd_wdata = 8'hC3;
    @(posedge clk);
    #1 cif.cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mid_pre_we", 32'(dut_we_n), 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_we_n",  32'(dut_we_n), 1);
    check("rst_mid_ce_n",  32'(dut_ce_n), 1);
    check("rst_mid_doe",   32'(dut_doe), 0);
    check("rst_mid_busy",  32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    kk = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) kk++;
    end
    check("rst_mid_no_done", 32'(kk), 0);
    check("rst_mid_ready",   32'(cif.cmd_ready), 1);

    check("oe_doe_overlap", 32'(overlap), 0);
    check("exp_q_empty",    32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound
  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hm62256_seq.md
# hm62256_seq

Clocked access sequencer for the HM62256 32Kx8 SRAM in the ZIF socket. It converts single and burst read/write commands from the microcontroller-side register logic into correctly timed /CE, /OE and /WE strobes, the address, and data-bus drive enables, with programmable setup, pulse and hold lengths. It sits between the command register file and the ZIF pin buffers, and replaces direct register-driven strobe toggling.

## Interface
- SETUP_CYC, 1, clk cycles of address/data setup before the strobe (≥1)
- PULSE_CYC, 4, clk cycles of the /WE low or /OE low pulse (≥1)
- HOLD_CYC, 1, clk cycles of hold after the strobe deasserts (≥1)
- clk  in  1  system clock; every register updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accept; a command transfers when cmd_valid && cmd_ready
- cmd_op  in  2  00 read, 01 write, 10 burst write (fill), 11 burst read
- cmd_addr  in  15  start address
- cmd_len  in  15  burst access count minus 1; ignored for single ops
- cmd_wdata  in  8  write/fill data; expected data for verify
- abort  in  1  request early burst termination
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at end of a command
- rd_valid  out  1  one-cycle pulse; rd_data valid
- rd_data  out  8  sampled read byte
- dut_addr  out  15  SRAM A14..A0
- dut_dout  out  8  data driven to DQ7..0
- dut_doe  out  1  DQ drive enable, 1 = FPGA drives
- dut_din  in  8  DQ7..0 as read from the pins
- dut_ce_n, dut_oe_n, dut_we_n  out  1 each  active-low SRAM strobes
- err  out  1  sticky verify mismatch (present only with verify compiled in)
- err_addr  out  15  address of the first mismatch (present only with verify compiled in)

## Operation
- The FSM has four states: IDLE, SETUP, PULSE and HOLD. A single down-counter is loaded with the phase length minus 1 on each phase entry.
- IDLE: cmd_ready=1. On accept, the FSM latches op, addr, len and wdata, then enters SETUP.
- SETUP: ce_n=0 and the address is driven. For writes, doe=1 and dout=wdata. we_n=1 and oe_n=1.
- PULSE: writes hold we_n=0. Reads hold oe_n=0 and doe=0. dut_din is sampled on the last PULSE cycle.
- HOLD: we_n=1, oe_n=1 and ce_n=1. For writes, doe stays 1 with the data held.
- After the final HOLD cycle, if accesses remain and no abort is pending, the address increments and the FSM enters SETUP. Otherwise it enters IDLE and pulses done.
- Address arithmetic is 15-bit modulo: 0x7FFF+1 wraps to 0x0000. The remaining-access counter is 15 bits.
- oe_n=0 and doe=1 are never asserted in the same cycle. This holds even across write/read command boundaries, because HOLD separates them.
- Abort is sampled only while busy and sets a pending flag. The current access always completes through HOLD, so a /WE pulse is never truncated. The command then ends with done. Abort in IDLE, including the accept cycle, is ignored.
- cmd_valid while busy is ignored. The requester holds it until cmd_ready.
- Reset values: ce_n=oe_n=we_n=1, doe=0, dut_addr=0, dut_dout=0, busy=0, done=0, rd_valid=0, rd_data=0, cmd_ready=1, err=0, err_addr=0. An asserted rst_n forces these immediately, even mid-pulse.

## Timing
- cmd_ready = !busy (combinational from state).
- A single access occupies SETUP_CYC+PULSE_CYC+HOLD_CYC cycles, starting the cycle after accept.
- done is asserted in the first IDLE cycle. The next command can be accepted in that same cycle.
- A burst of N accesses takes N×(SETUP_CYC+PULSE_CYC+HOLD_CYC) cycles.
- rd_valid/rd_data are registered from the last-PULSE sample and asserted in the first HOLD cycle.
- With defaults, a single write takes 6 cycles: accept at cycle 0, SETUP 1, PULSE 2–5, HOLD 6, done at 7.

## Configuration
- HM62256_SEQ_VERIFY_EN defined:
  - During burst reads, each sampled byte is compared with the latched wdata.
  - The first mismatch sets err and captures err_addr. Later mismatches do not change them.
  - err and err_addr clear when the next burst read is accepted.
  - rd_valid still pulses for every beat.
- HM62256_SEQ_VERIFY_EN undefined: the err and err_addr ports are absent and there is no compare logic.

## Test plan
- Reset then single write (defaults), addr 0x1234, data 0xA5 -> we_n low for exactly cycles 2–5, doe=1 for cycles 1–6, dut_addr 0x1234, done at cycle 7, no oe_n activity.
- Single read, addr 0x0042, with the model returning 0x5A -> oe_n low for 4 cycles, rd_valid once with 0x5A, doe=0 throughout.
- Burst write from 0x7FFE with len 3 and data 0x3C -> 4 /WE pulses at 0x7FFE, 0x7FFF, 0x0000, 0x0001, then a single done.
- Burst write with len 9 and abort asserted mid-PULSE of beat 2 -> beat 2 /WE pulse is full length, no beat 3, done follows beat 2 HOLD.
- Burst read of 8 bytes with expected 0xFF and the model corrupting addr 0x0005 to 0xFE -> 8 rd_valid pulses, err=1, err_addr=0x0005. With the macro undefined, no err port.
- rst_n asserted mid write PULSE -> we_n=1, ce_n=1 and doe=0 asynchronously. After release, cmd_ready=1 and no done.
